// File: rtl/branch_resolve_if.sv
// Decode/fetch/writeback-facing signal bundle of the branch resolve controller.
// The slave modport is the controller; the master modport is the core-side driver.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [2:0]      func3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            done_valid;
  logic            taken;
  logic [XLEN-1:0] link;
  logic [1:0]      exc;

  modport slave (
    input  in_valid, op, func3, pc, rs1, rs2, imm, redirect_ready,
    output in_ready, redirect_valid, redirect_pc, flush, done_valid, taken, link, exc
  );

  modport master (
    output in_valid, op, func3, pc, rs1, rs2, imm, redirect_ready,
    input  in_ready, redirect_valid, redirect_pc, flush, done_valid, taken, link, exc
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution sequencer: evaluate condition, redirect fetch, hold a
// flush window, then report taken/link/exception to writeback.
//
// state      | meaning
// S_IDLE     | ready for a new control-transfer op
// S_EVAL     | condition, target and link computed from the captured op
// S_REDIRECT | redirect_valid held until fetch accepts
// S_FLUSH    | flush held for FLUSH_CYCLES cycles via down-counter
// S_DONE     | one-cycle completion pulse to writeback
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  branch_resolve_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_REDIRECT, S_FLUSH, S_DONE} state_e;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [2:0]      func3_q, func3_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [XLEN-1:0] target_q, target_d, link_q, link_d;
  logic [1:0]      exc_q, exc_d;
  logic            taken_q, taken_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            cond;
  logic            take;
  logic            illegal;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  always_comb begin
    cond     = 1'b0;
    take     = 1'b0;
    illegal  = 1'b0;
    jalr_sum = rs1_q + imm_q;
    target   = pc_q + imm_q;
    case (func3_q)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
    case (op_q)
      2'b00: begin
        take    = cond;
        illegal = (func3_q[2:1] == 2'b01);
      end
      2'b01: take = 1'b1;
      2'b10: begin
        take   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    func3_d  = func3_q;
    pc_d     = pc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    target_d = target_q;
    link_d   = link_q;
    exc_d    = exc_q;
    taken_d  = taken_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          func3_d = bus.func3;
          pc_d    = bus.pc;
          rs1_d   = bus.rs1;
          rs2_d   = bus.rs2;
          imm_d   = bus.imm;
          exc_d   = 2'b00;
          taken_d = 1'b0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        target_d = target;
        link_d   = pc_q + XLEN'(4);
        if (illegal) begin
          exc_d   = 2'b01;
          state_d = S_DONE;
        end else if (take && target[1]) begin
          exc_d   = 2'b10;
          state_d = S_DONE;
        end else if (take) begin
          state_d = S_REDIRECT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          taken_d = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            cnt_d   = CNT_LOAD;
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      func3_q  <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      target_q <= '0;
      link_q   <= '0;
      exc_q    <= '0;
      taken_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      func3_q  <= func3_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      link_q   <= link_d;
      exc_q    <= exc_d;
      taken_q  <= taken_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake outputs decode from state only, so no input reaches them combinationally.
  assign bus.in_ready       = (state_q == S_IDLE);
  assign bus.redirect_valid = (state_q == S_REDIRECT);
  assign bus.flush          = (state_q == S_FLUSH);
  assign bus.done_valid     = (state_q == S_DONE);
  assign bus.redirect_pc    = target_q;
  assign bus.taken          = taken_q;
  assign bus.link           = link_q;
  assign bus.exc            = exc_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl with FLUSH_CYCLES=2 and =0 instances.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [1:0]  op;
  logic [2:0]  func3;
  logic [31:0] pc, rs1, rs2, imm;
  logic        redirect_ready;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) if2 ();
  branch_resolve_if #(.XLEN(32)) if0 ();

  assign if2.in_valid       = in_valid & ~sel;
  assign if0.in_valid       = in_valid & sel;
  assign if2.op             = op;
  assign if0.op             = op;
  assign if2.func3          = func3;
  assign if0.func3          = func3;
  assign if2.pc             = pc;
  assign if0.pc             = pc;
  assign if2.rs1            = rs1;
  assign if0.rs1            = rs1;
  assign if2.rs2            = rs2;
  assign if0.rs2            = rs2;
  assign if2.imm            = imm;
  assign if0.imm            = imm;
  assign if2.redirect_ready = redirect_ready;
  assign if0.redirect_ready = redirect_ready;

  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  logic        m_in_ready, m_rv, m_flush, m_done, m_taken;
  logic [31:0] m_rpc, m_link;
  logic [1:0]  m_exc;

  always_comb begin
    m_in_ready = sel ? if0.in_ready       : if2.in_ready;
    m_rv       = sel ? if0.redirect_valid : if2.redirect_valid;
    m_flush    = sel ? if0.flush          : if2.flush;
    m_done     = sel ? if0.done_valid     : if2.done_valid;
    m_taken    = sel ? if0.taken          : if2.taken;
    m_rpc      = sel ? if0.redirect_pc    : if2.redirect_pc;
    m_link     = sel ? if0.link           : if2.link;
    m_exc      = sel ? if0.exc            : if2.exc;
  end

  typedef struct {
    logic        taken;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] link;
    logic [1:0]  exc;
    int          nfl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic tk, input logic rd, input logic [31:0] rpc,
                              input logic [31:0] link, input logic [1:0] ex, input int nfl, input int lat);
    exp_t e;
    e.taken = tk; e.redir = rd; e.rpc = rpc; e.link = link; e.exc = ex; e.nfl = nfl; e.lat = lat;
    return e;
  endfunction

  // Monitor: tracks redirect/flush activity of the current op and scores it at done_valid.
  int          acc_cyc = 0;
  int          flush_n = 0;
  int          done_cnt = 0;
  logic        saw_redir = 1'b0, rpc_bad = 1'b0, busy_bad = 1'b0;
  logic [31:0] rpc_seen = '0;

  always @(negedge clk) begin
    if (rst) begin
      saw_redir = 1'b0; rpc_bad = 1'b0; busy_bad = 1'b0; flush_n = 0;
    end else begin
      if (in_valid && m_in_ready) begin
        acc_cyc = cyc; saw_redir = 1'b0; rpc_bad = 1'b0; busy_bad = 1'b0; flush_n = 0;
      end
      if (m_in_ready && (m_rv || m_flush || m_done)) busy_bad = 1'b1;
      if (m_rv) begin
        if (saw_redir && (m_rpc !== rpc_seen)) rpc_bad = 1'b1;
        saw_redir = 1'b1;
        rpc_seen  = m_rpc;
      end
      if (m_flush) flush_n++;
      if (m_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_valid=1, expected no completion");
        end else begin
          e_cur = sb.pop_front();
          chk("taken",         m_taken,   e_cur.taken);
          chk("link",          m_link,    e_cur.link);
          chk("exc",           m_exc,     e_cur.exc);
          chk("redirect_seen", saw_redir, e_cur.redir);
          if (e_cur.redir) begin
            chk("redirect_pc",        rpc_seen, e_cur.rpc);
            chk("redirect_pc_stable", rpc_bad,  1'b0);
          end
          chk("flush_cycles",  flush_n,        e_cur.nfl);
          chk("done_latency",  cyc - acc_cyc,  e_cur.lat);
          chk("in_ready_busy", busy_bad,       1'b0);
        end
      end
    end
  end

  task automatic wait_done();
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL timeout_done: got no done_valid within 60 cycles, expected one");
      sb.delete();
    end
    #1;
  endtask

  // hold = cycles redirect_ready stays low; in_valid is pulsed meanwhile to prove it is ignored.
  task automatic run_op(input logic [1:0] o, input logic [2:0] f, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                        input exp_t e, input int hold);
    sb.push_back(e);
    redirect_ready = (hold == 0);
    op = o; func3 = f; pc = p; rs1 = a; rs2 = b; imm = i;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold > 0) begin
      for (int k = 0; k <= hold; k++) begin
        @(posedge clk); #1;
        in_valid = (k < hold) && (k % 2 == 0);
      end
      redirect_ready = 1'b1;
    end
    wait_done();
    redirect_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; op = '0; func3 = '0;
    pc = '0; rs1 = '0; rs2 = '0; imm = '0; redirect_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",     if2.in_ready,       1'b1);
    chk("rst_redirect",     if2.redirect_valid, 1'b0);
    chk("rst_flush",        if2.flush,          1'b0);
    chk("rst_done",         if2.done_valid,     1'b0);
    chk("rst_taken",        if2.taken,          1'b0);
    chk("rst_link",         if2.link,           32'h0);
    chk("rst_redirect_pc",  if2.redirect_pc,    32'h0);
    chk("rst_in_ready_f0",  if0.in_ready,       1'b1);

    // FLUSH_CYCLES = 2 instance
    run_op(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, mk(1, 1, 32'h120, 32'h104, 2'b00, 2, 5), 0);
    run_op(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, mk(1, 1, 32'h240, 32'h204, 2'b00, 2, 5), 0);
    run_op(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, mk(0, 0, 32'h0, 32'h204, 2'b00, 0, 2), 0);
    run_op(2'b00, 3'b101, 32'h220, 32'hFFFF_FFFF, 32'd1, 32'h40, mk(0, 0, 32'h0, 32'h224, 2'b00, 0, 2), 0);
    run_op(2'b00, 3'b111, 32'h240, 32'hFFFF_FFFF, 32'd1, 32'h10, mk(1, 1, 32'h250, 32'h244, 2'b00, 2, 5), 0);
    run_op(2'b00, 3'b001, 32'h260, 32'd9, 32'd9, 32'h10, mk(0, 0, 32'h0, 32'h264, 2'b00, 0, 2), 0);
    run_op(2'b10, 3'b000, 32'h300, 32'h203, 32'd0, 32'h0, mk(0, 0, 32'h0, 32'h304, 2'b10, 0, 2), 0);
    run_op(2'b10, 3'b000, 32'h310, 32'h1001, 32'd0, 32'h3, mk(1, 1, 32'h1004, 32'h314, 2'b00, 2, 5), 0);
    run_op(2'b10, 3'b011, 32'h320, 32'h2000, 32'd0, 32'hFFFF_FFFD, mk(1, 1, 32'h1FFC, 32'h324, 2'b00, 2, 5), 0);
    run_op(2'b01, 3'b010, 32'h400, 32'd0, 32'd0, 32'h8, mk(1, 1, 32'h408, 32'h404, 2'b00, 2, 9), 4);
    run_op(2'b00, 3'b010, 32'h500, 32'd1, 32'd1, 32'h8, mk(0, 0, 32'h0, 32'h504, 2'b01, 0, 2), 0);
    run_op(2'b00, 3'b011, 32'h510, 32'd1, 32'd1, 32'h8, mk(0, 0, 32'h0, 32'h514, 2'b01, 0, 2), 0);
    run_op(2'b11, 3'b000, 32'h600, 32'd1, 32'd1, 32'h8, mk(0, 0, 32'h0, 32'h604, 2'b01, 0, 2), 0);
    run_op(2'b01, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, mk(1, 1, 32'h4, 32'h0, 2'b00, 2, 5), 0);
    run_op(2'b01, 3'b000, 32'h700, 32'd0, 32'd0, 32'h6, mk(0, 0, 32'h0, 32'h704, 2'b10, 0, 2), 0);

    // Reset during the flush window aborts the op; no completion is expected.
    op = 2'b00; func3 = 3'b000; pc = 32'h100; rs1 = 32'd7; rs2 = 32'd7; imm = 32'h20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_flush", if2.flush, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_flush",    if2.flush,          1'b0);
    chk("mid_rst_done",     if2.done_valid,     1'b0);
    chk("mid_rst_redirect", if2.redirect_valid, 1'b0);
    chk("mid_rst_in_ready", if2.in_ready,       1'b1);
    rst = 1'b0;
    run_op(2'b00, 3'b001, 32'h800, 32'd1, 32'd2, 32'h10, mk(1, 1, 32'h810, 32'h804, 2'b00, 2, 5), 0);

    // FLUSH_CYCLES = 0 instance
    sel = 1'b1;
    run_op(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, mk(1, 1, 32'h120, 32'h104, 2'b00, 0, 3), 0);
    run_op(2'b01, 3'b000, 32'h900, 32'd0, 32'd0, 32'h100, mk(1, 1, 32'hA00, 32'h904, 2'b00, 0, 5), 2);
    run_op(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, mk(0, 0, 32'h0, 32'h204, 2'b00, 0, 2), 0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencing controller for branch and jump resolution in the single-issue RISC-V core. It accepts one control-transfer op at a time from decode and evaluates the branch condition from func3. It computes the target and link address, then drives a handshaked redirect to fetch followed by a pipeline flush window. It reports completion to writeback with taken/link/exception status.

Parameters:
XLEN, 32, operand/address width
FLUSH_CYCLES, 2, cycles flush is held high after redirect is accepted (0 = no flush window)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
in_valid  input  1  decode presents an op
in_ready  output  1  controller can accept an op
op  input  2  00 branch, 01 jal, 10 jalr, 11 reserved
func3  input  3  branch condition code
pc  input  XLEN  PC of the op
rs1  input  XLEN  operand A
rs2  input  XLEN  operand B
imm  input  XLEN  sign-extended offset
redirect_valid  output  1  redirect request to fetch
redirect_ready  input  1  fetch accepts redirect
redirect_pc  output  XLEN  new fetch PC
flush  output  1  kill younger instructions
done_valid  output  1  one-cycle completion pulse
taken  output  1  redirect performed (valid with done_valid)
link  output  XLEN  pc+4 (valid with done_valid)
exc  output  2  00 none, 01 illegal func3/op, 10 misaligned target (valid with done_valid)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- States: IDLE, EVAL, REDIRECT, FLUSH, DONE. Reset to IDLE.
- Reset values: all registered outputs 0 and counter 0. in_ready is decoded as state==IDLE, so it reads 1 in the cycle after reset.
- Reset mid-operation aborts at the next edge: state IDLE, and redirect_valid, flush and done_valid drop to 0.
- IDLE:
  - in_ready=1.
  - When in_valid is high, capture op, func3, pc, rs1, rs2, imm -> EVAL.
- EVAL (exactly 1 cycle):
  - Condition by func3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - func3 010/011 -> exc=01, not taken.
  - jal/jalr are always taken; func3 is ignored for them.
  - op 11 -> exc=01, not taken.
  - Target: branch/jal = pc+imm; jalr = (rs1+imm) with bit0 cleared. All arithmetic is modulo 2^XLEN, wrap ignored.
  - link = pc+4, computed modulo 2^XLEN.
  - Taken with target[1]=1 -> exc=10, no redirect -> DONE.
  - Taken and aligned -> REDIRECT; otherwise -> DONE.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=target, both held stable until redirect_ready is seen high.
  - On a cycle with valid&ready: -> FLUSH if FLUSH_CYCLES>0, else -> DONE.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles, the first being the cycle after the handshake.
  - A down-counter is loaded on the handshake; -> DONE when it expires.
- DONE:
  - done_valid=1 for one cycle, with taken, link and exc stable -> IDLE.
  - taken=1 only when a redirect handshake occurred.
- Throughput: in_ready is 0 outside IDLE; in_valid is ignored there.
- Minimum latency, not taken: accept at cycle 0, EVAL at 1, done_valid at 2, in_ready at 3.
- Taken with immediate ready and FLUSH_CYCLES=2: redirect_valid at 2, flush at 3–4, done_valid at 5.
- No combinational path from in_valid or redirect_ready to any output except through state.

Test Plan:
1. beq, rs1=rs2=5, pc=0x100, imm=0x20, redirect_ready=1 -> redirect_pc=0x120 at cycle 2; flush cycles 3–4; done_valid cycle 5 with taken=1, link=0x104, exc=00.
2. blt rs1=0xFFFFFFFF, rs2=1 -> taken. bltu with the same operands -> not taken: done_valid at cycle 2, no redirect_valid, no flush.
3. jalr rs1=0x203, imm=0 -> target 0x202 (bit1 set) -> exc=10, taken=0, no redirect. jalr rs1=0x1001, imm=3 -> redirect_pc=0x1004.
4. jal pc=0x400, imm=8, redirect_ready held low 4 cycles -> redirect_valid and redirect_pc=0x408 stable throughout; in_ready=0; pulsing in_valid is ignored; flush starts the cycle after ready.
5. func3=010 branch -> exc=01, taken=0, done_valid at cycle 2. op=11 -> same result.
6. rst asserted during FLUSH -> next cycle flush=0, done_valid=0, in_ready=1. A new bne rs1=1, rs2=2 then completes normally. Also run with FLUSH_CYCLES=0: done_valid the cycle after the handshake, flush never asserted.
